bit_parse: RTL and testbench
============================

Name: bit_parse

Overview:
- Per-substream entropy/bit parser for the VDC-M style block decoder.
- Pulls 128-bit words from its substream word buffer and holds them in a bit buffer.
- Extracts one block's worth of MPP quantized residuals at a time: 16 samples, each sign-extended to 8 bits.
- Four instances run in parallel (substreams 0..3) and feed the MPP reconstruction stage (dec_mpp, specified separately).

Parameters:
- SSM_IDX, 0, substream index 0..3; only substream 0 carries the 8-bit block header.
- DATA_W, 128, input word width.
- BLK_SAMPLES, 16, residuals per block.
- QRES_W, 8, output residual width.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start_dec  in  1  level/pulse; first high sample enables parsing.
- codec_data  in  128  current substream word, valid combinationally in any cycle; MSB is first bit.
- codec_data_rd_en  out  1  when high, codec_data is consumed at this rising edge; the source advances its pointer.
- pnxt_blk_quant  out  16x8  residuals of last parsed block; element 0 = first in bitstream; two's complement.
- blk_valid  out  1  one-cycle pulse when pnxt_blk_quant is updated.

Behaviour:
- Reset (rst high at edge) clears the following to 0:
  - started flag
  - 256-bit buffer
  - fill count (0..256)
  - pnxt_blk_quant
  - blk_valid
  - codec_data_rd_en (forced low while rst is high)
  - Reset mid-operation discards all buffered bits and any in-flight block.
- started: set at the first edge where start_dec=1; sticky until reset. Later start_dec values are ignored.
- Read request: codec_data_rd_en = started && fill <= 128, combinational from registered state only.
  - On rd_en edge: codec_data is appended below the existing valid bits (MSB-aligned buffer); fill += 128.
- Block format, MSB-first, bit-contiguous across word boundaries:
  - SSM_IDX==0 only: 8-bit header, parsed and discarded.
  - 4-bit width field W. Effective width Weff = W for 1..8; W=0 or W>8 gives Weff=8.
  - 16 residuals of Weff bits each, two's complement, sign-extended to 8 bits.
  - H = 8 if SSM_IDX==0 else 0. Block length L = H + 4 + 16*Weff; max 140 bits.
- Parse condition, evaluated each cycle on the registered buffer: fill >= H+4 and fill >= L.
  - When true, at the edge: register the 16 residuals, pulse blk_valid, shift the buffer left by L, fill -= L.
- At most one block per cycle. Block output latency is one edge after the condition holds.
- Read and consume in the same cycle: fill_next = fill - L + 128. Bits are appended after the shift; no bits are lost or duplicated.
- Overflow cannot occur; reads are only issued when fill <= 128.
- pnxt_blk_quant holds its value between blocks. blk_valid is low otherwise.
- Nominal timing after start:
  - start_dec edge E0.
  - rd_en high in cycle after E0; word loaded at E1.
  - If one word suffices: blk_valid high and data visible after E2.

Decomposition:
- Package bit_parse_pkg with constants:
  - DATA_W=128, BLK_SAMPLES=16, QRES_W=8, HDR_W=8, WID_W=4, BUF_W=256.
  - Function weff(W).
- One sub-module: bit_field_extract.
  - Combinational.
  - Takes the 256-bit buffer and Weff.
  - Returns the 16 sign-extended residuals and L.
- The top handles buffer, fill, read control and registers.

Test Plan:
- Reset/idle: rst high 2 cycles, start_dec=0 for 20 cycles -> rd_en=0, blk_valid=0, all residuals 0x00.
- SSM_IDX=1, word 0x4_0123456789ABCDEF_000... ; start_dec pulse -> one rd_en, then blk_valid once with:
  - residuals 00..07 = 0x00..0x07
  - residuals 08..15 = 0xF8..0xFF
  - fill = 60, then second rd_en.
- SSM_IDX=0, header 0xA5, W=8, residuals 0x80,0x7F,... spanning words 0 and 1 -> two rd_en before first blk_valid; residual0=0x80, residual1=0x7F; fill after parse = 116.
- W=0 and W=9 blocks -> each parsed as Weff=8 (132 bits, SSM_IDX=1); output identical to the W=8 stream.
- Back-to-back W=1 blocks (20 bits each) -> blk_valid every cycle while data is available; residual values 0x00 or 0xFF; rd_en only when fill <= 128; fill never exceeds 256.
- Assert rst during a block spanning two words -> no blk_valid after reset until restart; after start_dec, parsing restarts from the then-current codec_data word.

Source files
------------

// File: rtl/bit_parse_pkg.sv
// Shared constants and helpers for the per-substream bit parser.
package bit_parse_pkg;
  localparam int DATA_W      = 128;
  localparam int BLK_SAMPLES = 16;
  localparam int QRES_W      = 8;
  localparam int HDR_W       = 8;
  localparam int WID_W       = 4;
  localparam int BUF_W       = 256;

  // Out-of-range width codes (0 and 9..15) decode as full 8-bit residuals.
  function automatic logic [3:0] weff(input logic [3:0] w);
    return ((w == 4'd0) || (w > 4'd8)) ? 4'd8 : w;
  endfunction
endpackage

// File: rtl/bit_field_extract.sv
// Combinational slicer: pulls 16 sign-extended residuals and the block
// length out of an MSB-aligned bit buffer for a given effective width.
module bit_field_extract
  import bit_parse_pkg::*;
#(
  parameter int HDR_BITS = 0
) (
  input  logic [BUF_W-1:0]                        bit_buf,
  input  logic [3:0]                              weff_in,
  output logic [BLK_SAMPLES-1:0][QRES_W-1:0]      qres,
  output logic [7:0]                              blk_len
);

  assign blk_len = 8'(HDR_BITS + WID_W) + {weff_in, 4'b0000};

  genvar gi;
  generate
    for (gi = 0; gi < BLK_SAMPLES; gi++) begin : g_samp
      logic [8:0] off;
      logic [7:0] top8;

      assign off  = 9'(HDR_BITS + WID_W) + 9'(gi) * {5'd0, weff_in};
      // Bring the 8 bits starting at 'off' down to the LSBs, then drop the
      // trailing bits that belong to the next field with an arithmetic shift.
      assign top8 = 8'(bit_buf >> (9'd248 - off));
      assign qres[gi] = $signed(top8) >>> (4'd8 - weff_in);
    end
  endgenerate

endmodule

// File: rtl/bit_parse.sv
// Per-substream bit parser: buffers 128-bit words and emits one block of
// 16 quantized residuals per parse.
module bit_parse #(
  parameter int SSM_IDX     = 0,
  parameter int DATA_W      = 128,
  parameter int BLK_SAMPLES = 16,
  parameter int QRES_W      = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start_dec,
  input  logic [DATA_W-1:0]                   codec_data,
  output logic                                codec_data_rd_en,
  output logic [BLK_SAMPLES-1:0][QRES_W-1:0]  pnxt_blk_quant,
  output logic                                blk_valid
);
  import bit_parse_pkg::*;

  localparam int HDR_BITS = (SSM_IDX == 0) ? HDR_W : 0;

  logic                               started_reg, started_next;
  logic [BUF_W-1:0]                   buf_reg, buf_next, buf_shift;
  logic [8:0]                         fill_reg, fill_next, fill_shift;
  logic [BLK_SAMPLES-1:0][QRES_W-1:0] quant_reg;
  logic                               blk_valid_reg;

  logic [3:0]                         w_field;
  logic [3:0]                         weff_cur;
  logic [BLK_SAMPLES-1:0][QRES_W-1:0] qres;
  logic [7:0]                         blk_len;
  logic                               parse;
  logic                               rd_en;

  assign w_field  = buf_reg[BUF_W-1-HDR_BITS -: WID_W];
  assign weff_cur = weff(w_field);

  bit_field_extract #(
    .HDR_BITS (HDR_BITS)
  ) u_extract (
    .bit_buf (buf_reg),
    .weff_in (weff_cur),
    .qres    (qres),
    .blk_len (blk_len)
  );

  // The width field must be present before blk_len can be trusted.
  assign parse = (fill_reg >= 9'(HDR_BITS + WID_W)) && (fill_reg >= {1'b0, blk_len});
  assign rd_en = !rst && started_reg && (fill_reg <= 9'd128);

  always_comb begin
    started_next = started_reg | start_dec;
    buf_shift    = parse ? (buf_reg << blk_len) : buf_reg;
    fill_shift   = parse ? (fill_reg - {1'b0, blk_len}) : fill_reg;
    buf_next     = buf_shift;
    fill_next    = fill_shift;
    // The new word lands directly below the bits that survive this cycle's parse.
    if (rd_en) begin
      buf_next  = buf_shift | ({codec_data, {DATA_W{1'b0}}} >> fill_shift);
      fill_next = fill_shift + 9'd128;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      started_reg   <= 1'b0;
      buf_reg       <= '0;
      fill_reg      <= '0;
      quant_reg     <= '0;
      blk_valid_reg <= 1'b0;
    end else begin
      started_reg   <= started_next;
      buf_reg       <= buf_next;
      fill_reg      <= fill_next;
      blk_valid_reg <= parse;
      if (parse) begin
        quant_reg <= qres;
      end
    end
  end

  assign codec_data_rd_en = rd_en;
  assign pnxt_blk_quant   = quant_reg;
  assign blk_valid        = blk_valid_reg;

endmodule

// File: tb/tb_bit_parse.sv
// Bench for bit_parse: two instances (substream 0 and 1) fed from bit streams
// built here, with expected blocks queued as the streams are assembled.
module tb_bit_parse;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic                 start0, start1;
  logic [127:0]         data0, data1;
  logic                 rd0, rd1;
  logic [15:0][7:0]     q0, q1;
  logic                 bv0, bv1;

  bit_parse #(.SSM_IDX(0)) dut0 (
    .clk              (clk),
    .rst              (rst),
    .start_dec        (start0),
    .codec_data       (data0),
    .codec_data_rd_en (rd0),
    .pnxt_blk_quant   (q0),
    .blk_valid        (bv0)
  );

  bit_parse #(.SSM_IDX(1)) dut1 (
    .clk              (clk),
    .rst              (rst),
    .start_dec        (start1),
    .codec_data       (data1),
    .codec_data_rd_en (rd1),
    .pnxt_blk_quant   (q1),
    .blk_valid        (bv1)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Word sources: the pointer advances on every rd_en edge.
  logic [127:0] mem0 [64];
  logic [127:0] mem1 [64];
  int ptr0 = 0;
  int ptr1 = 0;
  int off1 = 0;

  assign data0 = (ptr0 >= 0 && ptr0 < 64) ? mem0[ptr0] : '0;
  assign data1 = (ptr1 + off1 >= 0 && ptr1 + off1 < 64) ? mem1[ptr1 + off1] : '0;

  always @(posedge clk) begin
    if (rd0) ptr0 <= ptr0 + 1;
    if (rd1) ptr1 <= ptr1 + 1;
  end

  // Stream builder and scoreboard
  bit           bitq [$];
  logic [127:0] exp0 [$];
  logic [127:0] exp1 [$];

  task automatic push_bits(input logic [7:0] v, input int n);
    for (int i = n - 1; i >= 0; i--) bitq.push_back(v[i]);
  endtask

  task automatic add_block(input int inst, input logic [7:0] hdr, input logic [3:0] wf,
                           input int weff, input logic [15:0][7:0] vals, input bit push);
    if (inst == 0) push_bits(hdr, 8);
    push_bits({4'b0000, wf}, 4);
    for (int i = 0; i < 16; i++) push_bits(vals[i], weff);
    if (push) begin
      if (inst == 0) exp0.push_back(vals);
      else           exp1.push_back(vals);
    end
  endtask

  task automatic pad_to(input int nbits);
    while (bitq.size() < nbits) bitq.push_back(1'b0);
  endtask

  task automatic pack(input int inst);
    logic [127:0] w;
    for (int k = 0; k < 64; k++) begin
      w = '0;
      for (int j = 0; j < 128; j++)
        if (k * 128 + j < bitq.size()) w[127 - j] = bitq[k * 128 + j];
      if (inst == 0) mem0[k] = w;
      else           mem1[k] = w;
    end
    bitq.delete();
  endtask

  // Output monitor: compares each block against the scoreboard.
  bit strict = 1'b0;
  int run1 = 0;
  int max_run1 = 0;
  logic [127:0] exp_tmp;

  always @(negedge clk) begin
    if (!rst) begin
      if (bv0) begin
        if (exp0.size() > 0) begin
          exp_tmp = exp0.pop_front();
          $display("ssm0 block %h expected %h", q0, exp_tmp);
          check_eq("blk0", q0, exp_tmp);
        end else if (strict) begin
          check_eq("extra0", 128'(bv0), 128'd0);
        end
      end
      if (bv1) begin
        run1++;
        if (run1 > max_run1) max_run1 = run1;
        if (exp1.size() > 0) begin
          exp_tmp = exp1.pop_front();
          $display("ssm1 block %h expected %h", q1, exp_tmp);
          check_eq("blk1", q1, exp_tmp);
        end else if (strict) begin
          check_eq("extra1", 128'(bv1), 128'd0);
        end
      end else begin
        run1 = 0;
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  logic [15:0][7:0] v4, v8, v1a, v1b, sa, v3, v2;

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;

    for (int i = 0; i < 16; i++) begin
      v4[i]  = (i < 8) ? 8'(i) : (8'(i) | 8'hF0);
      v8[i]  = 8'(i * 37 + 5);
      v1a[i] = (i % 3 == 0) ? 8'hFF : 8'h00;
      v1b[i] = (i % 2 == 1) ? 8'hFF : 8'h00;
      sa[i]  = 8'(i * 29);
      v3[i]  = ((i % 8) < 4) ? 8'(i % 8) : (8'(i % 8) | 8'hF8);
      v2[i]  = ((i % 4) < 2) ? 8'(i % 4) : (8'(i % 4) | 8'hFC);
    end
    sa[0] = 8'h80;
    sa[1] = 8'h7F;

    // Substream 1: W=4 block, W=0/W=9/W=8 blocks (all 8-bit), then twelve W=1 blocks.
    add_block(1, 8'h00, 4'd4, 4, v4, 1'b1);
    add_block(1, 8'h00, 4'd0, 8, v8, 1'b1);
    add_block(1, 8'h00, 4'd9, 8, v8, 1'b1);
    add_block(1, 8'h00, 4'd8, 8, v8, 1'b1);
    for (int k = 0; k < 12; k++) add_block(1, 8'h00, 4'd1, 1, (k % 2 == 1) ? v1b : v1a, 1'b1);
    pack(1);

    // Substream 0: headered blocks, first one spans two words.
    add_block(0, 8'hA5, 4'd8, 8, sa, 1'b1);
    add_block(0, 8'h3C, 4'd3, 3, v3, 1'b1);
    add_block(0, 8'h00, 4'd12, 8, v8, 1'b1);
    pack(0);

    // Reset and idle
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_eq("idle_rd0", 128'(rd0), 128'd0);
      check_eq("idle_rd1", 128'(rd1), 128'd0);
      check_eq("idle_bv0", 128'(bv0), 128'd0);
      check_eq("idle_bv1", 128'(bv1), 128'd0);
    end
    check_eq("idle_q0", q0, 128'd0);
    check_eq("idle_q1", q1, 128'd0);

    // Start both and check nominal latency
    start0 = 1'b1;
    start1 = 1'b1;
    tick();                                   // after E0
    start0 = 1'b0;
    start1 = 1'b0;
    check_eq("rd0_e0", 128'(rd0), 128'd1);
    check_eq("rd1_e0", 128'(rd1), 128'd1);
    tick();                                   // after E1
    check_eq("bv1_e1", 128'(bv1), 128'd0);
    check_eq("bv0_e1", 128'(bv0), 128'd0);
    check_eq("rd0_e1", 128'(rd0), 128'd1);
    tick();                                   // after E2
    check_eq("bv1_e2", 128'(bv1), 128'd1);
    check_eq("bv0_e2", 128'(bv0), 128'd0);
    tick();                                   // after E3
    check_eq("bv0_e3", 128'(bv0), 128'd1);

    for (int i = 0; i < 2000 && (exp0.size() > 0 || exp1.size() > 0); i++) tick();
    check_eq("drain", 128'(exp0.size() + exp1.size()), 128'd0);
    check_eq("w1_run", 128'(max_run1 >= 12), 128'd1);

    // Reset mid-block, then restart from a fresh word
    rst = 1'b1;
    tick();
    rst = 1'b0;
    add_block(1, 8'h00, 4'd8, 8, v8, 1'b0);
    pad_to(256);
    add_block(1, 8'h00, 4'd2, 2, v2, 1'b0);
    pack(1);
    off1 = -ptr1;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tick();                                   // first word of the block loaded
    rst = 1'b1;
    #1;
    check_eq("rd1_in_rst", 128'(rd1), 128'd0);
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_q1", q1, 128'd0);
    strict = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("post_rst_bv1", 128'(bv1), 128'd0);
      check_eq("post_rst_rd1", 128'(rd1), 128'd0);
    end
    strict = 1'b0;

    off1 = 2 - ptr1;
    exp1.push_back(v2);
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    check_eq("restart_rd1", 128'(rd1), 128'd1);
    tick();
    check_eq("restart_bv1_e1", 128'(bv1), 128'd0);
    tick();
    check_eq("restart_bv1_e2", 128'(bv1), 128'd1);
    tick();
    check_eq("restart_drain", 128'(exp1.size()), 128'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
